// File: rtl/reset_run_sequencer.sv
// Core reset/run sequencer: issues a train of reset pulses, releases the cores
// (optionally staggered), then times a run window that ends on halt or expiry.
module reset_run_sequencer #(
  parameter int CHANNELS   = 2,
  parameter int PULSES     = 2,
  parameter int PULSE_LEN  = 1,
  parameter int GAP_LEN    = 1,
  parameter int STAGGER    = 0,
  parameter int RUN_CYCLES = 300,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CHANNELS-1:0] halt,
  output logic [CHANNELS-1:0] core_rst_n,
  output logic                running,
  output logic                done,
  output logic                timeout,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [2:0]          fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PULSE   = 3'd1,
    GAP     = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4,
    DONE    = 3'd5
  } state_t;

  if ((RUN_CYCLES >> CNT_W) != 0) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold RUN_CYCLES");
  end

  // Zero-length pulse train or pulse collapses to the shortest meaningful one.
  localparam int unsigned PULSES_EFF = (PULSES < 1) ? 1 : PULSES;
  localparam int unsigned PULSE_EFF  = (PULSE_LEN < 1) ? 1 : PULSE_LEN;
  localparam int unsigned GAP_U      = GAP_LEN;
  localparam bit          DIRECT     = (STAGGER == 0) || (CHANNELS == 1);
  localparam int unsigned REL_LEN    = DIRECT ? 0 : (CHANNELS - 1) * STAGGER;
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_CYCLES);

  state_t              state, state_next;
  logic [31:0]         phase_cnt, phase_next;
  logic [31:0]         pulse_cnt, pulse_next;
  logic [CHANNELS-1:0] core_next;
  logic                running_next, done_next, timeout_next;
  logic [CNT_W-1:0]    count_next, count_inc;
  logic                expire, any_halt;

  assign count_inc = cycle_count + 1'b1;
  assign expire    = (count_inc == RUN_MAX);
  assign any_halt  = |halt;
  assign fsm_state = state;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      pulse_cnt   <= '0;
      core_rst_n  <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_next;
      phase_cnt   <= phase_next;
      pulse_cnt   <= pulse_next;
      core_rst_n  <= core_next;
      running     <= running_next;
      done        <= done_next;
      timeout     <= timeout_next;
      cycle_count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase_cnt;
    pulse_next = pulse_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = PULSE;
          phase_next = '0;
          pulse_next = '0;
        end
      end
      PULSE: begin
        if (phase_cnt == PULSE_EFF - 1) begin
          phase_next = '0;
          pulse_next = pulse_cnt + 1;
          if (pulse_cnt + 1 < PULSES_EFF)
            state_next = (GAP_U == 0) ? PULSE : GAP;
          else
            state_next = DIRECT ? RUN : RELEASE;
        end else begin
          phase_next = phase_cnt + 1;
        end
      end
      GAP: begin
        if (phase_cnt == GAP_U - 1) begin
          state_next = PULSE;
          phase_next = '0;
        end else begin
          phase_next = phase_cnt + 1;
        end
      end
      RELEASE: begin
        if (phase_cnt + 1 == REL_LEN) begin
          state_next = RUN;
          phase_next = '0;
        end else begin
          phase_next = phase_cnt + 1;
        end
      end
      RUN: begin
        if (any_halt || expire) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered, so they register with it.
  always_comb begin
    core_next    = '0;
    running_next = 1'b0;
    done_next    = 1'b0;
    timeout_next = timeout;
    count_next   = cycle_count;
    case (state_next)
      GAP: core_next = '1;
      RELEASE: begin
        for (int i = 0; i < CHANNELS; i++)
          core_next[i] = ((32'(i) * 32'(STAGGER)) <= phase_next);
      end
      RUN: begin
        core_next    = '1;
        running_next = 1'b1;
      end
      DONE: done_next = 1'b1;
      default: core_next = '0;
    endcase
    if (state == RUN) begin
      count_next = count_inc;
      if (state_next == DONE) timeout_next = ~any_halt;
    end else if (state_next == PULSE && (state == IDLE || state == DONE)) begin
      count_next   = '0;
      timeout_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_reset_run_sequencer.sv
// Bench for reset_run_sequencer: two configurations, randomized halts and
// stray start/halt pulses, per-cycle output trace checked from a queue.
module tb_reset_run_sequencer;

  localparam int W = 4 + 3 + 16;

  logic        clk = 1'b0;
  logic        reset_a, start_a, reset_b, start_b;
  logic [1:0]  halt_a, core_a;
  logic [3:0]  halt_b, core_b;
  logic        running_a, done_a, timeout_a, running_b, done_b, timeout_b;
  logic [15:0] count_a;
  logic [7:0]  count_b;
  logic [2:0]  state_a, state_b;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] e_a, e_b, act_a, act_b;

  int p_ch[2]  = '{2, 4};
  int p_pul[2] = '{2, 1};
  int p_pl[2]  = '{1, 2};
  int p_gap[2] = '{1, 1};
  int p_stg[2] = '{0, 3};
  int p_run[2] = '{300, 20};

  always #5 clk = ~clk;

  reset_run_sequencer dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .halt(halt_a),
    .core_rst_n(core_a), .running(running_a), .done(done_a),
    .timeout(timeout_a), .cycle_count(count_a), .fsm_state(state_a)
  );

  reset_run_sequencer #(
    .CHANNELS(4), .PULSES(1), .PULSE_LEN(2), .GAP_LEN(1), .STAGGER(3),
    .RUN_CYCLES(20), .CNT_W(8)
  ) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .halt(halt_b),
    .core_rst_n(core_b), .running(running_b), .done(done_b),
    .timeout(timeout_b), .cycle_count(count_b), .fsm_state(state_b)
  );

  // Reference model: cycles are numbered from the first PULSE cycle (t=0).
  function automatic int reset_phase_len(input int sel);
    int pe;
    pe = (p_pul[sel] < 1) ? 1 : p_pul[sel];
    return pe * p_pl[sel] + (pe - 1) * p_gap[sel];
  endfunction

  function automatic int run_start(input int sel);
    int rel;
    rel = (p_stg[sel] == 0 || p_ch[sel] == 1) ? 0 : (p_ch[sel] - 1) * p_stg[sel];
    return reset_phase_len(sel) + rel;
  endfunction

  function automatic int seq_len(input int sel, input int h);
    return run_start(sel) + ((h >= 0) ? h + 1 : p_run[sel]);
  endfunction

  function automatic logic [W-1:0] exp_at(input int sel, input int t, input int h);
    int rl, r0, run_len, cnt;
    logic [3:0] core, all_hi;
    logic run_b, dn, to;
    rl = reset_phase_len(sel);
    r0 = run_start(sel);
    run_len = (h >= 0) ? h + 1 : p_run[sel];
    all_hi = 4'((1 << p_ch[sel]) - 1);
    core = '0; run_b = 1'b0; dn = 1'b0; to = 1'b0; cnt = 0;
    if (t < rl) begin
      if ((t % (p_pl[sel] + p_gap[sel])) >= p_pl[sel]) core = all_hi;
    end else if (t < r0) begin
      for (int i = 0; i < p_ch[sel]; i++) core[i] = (i * p_stg[sel] <= t - rl);
    end else if (t < r0 + run_len) begin
      core = all_hi; run_b = 1'b1; cnt = t - r0;
    end else begin
      dn = 1'b1; to = (h < 0); cnt = run_len;
    end
    return {core, run_b, dn, to, 16'(cnt)};
  endfunction

  task automatic push_exp(input int sel, input logic [W-1:0] e);
    if (sel == 0) exp_a_q.push_back(e);
    else exp_b_q.push_back(e);
  endtask

  task automatic drive(input int sel, input logic rst, input logic st, input logic [3:0] hl);
    if (sel == 0) begin
      reset_a = rst; start_a = st; halt_a = hl[1:0];
    end else begin
      reset_b = rst; start_b = st; halt_b = hl;
    end
  endtask

  task automatic idle(input int sel, input int n);
    for (int k = 0; k < n; k++) begin
      push_exp(sel, '0);
      drive(sel, 1'b1, 1'b0, 4'($urandom_range(0, 15)));
      @(posedge clk); #1;
    end
  endtask

  // h: RUN cycle (count value) carrying a halt, -1 for none.
  // t_reset: cycle with reset low (start also high there), -1 for none.
  task automatic run_seq(input int sel, input int h, input int t_reset);
    int r0, total;
    r0 = run_start(sel);
    total = seq_len(sel, h);
    drive(sel, 1'b1, 1'b1, 4'($urandom_range(0, 15)));
    @(posedge clk); #1;
    for (int t = 0; t < total + 3; t++) begin
      logic st;
      logic [3:0] hl;
      if (t_reset >= 0 && t > t_reset) break;
      push_exp(sel, exp_at(sel, t, h));
      st = (t < total) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (t >= r0 && t < total)
        hl = (t - r0 == h) ? 4'((sel == 0) ? $urandom_range(1, 3) : $urandom_range(1, 15)) : 4'b0;
      else
        hl = 4'($urandom_range(0, 15));
      if (t == t_reset) drive(sel, 1'b0, 1'b1, hl);
      else drive(sel, 1'b1, st, hl);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: whenever an expectation is pending, compare the sampled outputs.
  always @(negedge clk) begin
    if (exp_a_q.size() > 0) begin
      e_a = exp_a_q.pop_front();
      act_a = {2'b00, core_a, running_a, done_a, timeout_a, count_a};
      checks++;
      if (act_a !== e_a) begin
        errors++;
        $display("FAIL seq_a @%0t got core=%b run=%b done=%b to=%b cnt=%0d exp core=%b run=%b done=%b to=%b cnt=%0d",
                 $time, act_a[22:19], act_a[18], act_a[17], act_a[16], act_a[15:0],
                 e_a[22:19], e_a[18], e_a[17], e_a[16], e_a[15:0]);
      end
    end
    if (exp_b_q.size() > 0) begin
      e_b = exp_b_q.pop_front();
      act_b = {core_b, running_b, done_b, timeout_b, 8'h00, count_b};
      checks++;
      if (act_b !== e_b) begin
        errors++;
        $display("FAIL seq_b @%0t got core=%b run=%b done=%b to=%b cnt=%0d exp core=%b run=%b done=%b to=%b cnt=%0d",
                 $time, act_b[22:19], act_b[18], act_b[17], act_b[16], act_b[15:0],
                 e_b[22:19], e_b[18], e_b[17], e_b[16], e_b[15:0]);
      end
    end
  end

  initial begin
    int h;
    reset_a = 1'b0; start_a = 1'b1; halt_a = '0;
    reset_b = 1'b0; start_b = 1'b1; halt_b = '0;
    repeat (2) @(posedge clk);
    #1;
    start_b = 1'b0;

    // Default configuration.
    idle(0, 3);
    run_seq(0, -1, -1);
    run_seq(0, 41, -1);
    run_seq(0, 299, -1);
    idle(0, 0);
    run_seq(0, -1, 1);
    idle(0, 3);
    run_seq(0, -1, run_start(0) + 100);
    idle(0, 2);
    run_seq(0, 5, -1);
    for (int r = 0; r < 3; r++) begin
      h = $urandom_range(0, 340);
      run_seq(0, (h > 299) ? -1 : h, -1);
    end

    // Staggered four-channel configuration.
    idle(1, 3);
    run_seq(1, -1, -1);
    run_seq(1, 4, -1);
    run_seq(1, 19, -1);
    run_seq(1, -1, 5);
    idle(1, 2);
    run_seq(1, 0, -1);
    for (int r = 0; r < 6; r++) begin
      h = $urandom_range(0, 25);
      run_seq(1, (h > 19) ? -1 : h, -1);
    end
    idle(1, 0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL drain got a=%0d b=%0d pending exp 0", exp_a_q.size(), exp_b_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_run_sequencer.md
RESET_RUN_SEQUENCER -- requirements
Module: reset_run_sequencer

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent core reset outputs.
REQ-002 Parameter PULSES, default 2: reset pulses issued per sequence.
REQ-003 Parameter PULSE_LEN, default 1: cycles each reset pulse is held asserted.
REQ-004 Parameter GAP_LEN, default 1: deasserted cycles between consecutive pulses.
REQ-005 Parameter STAGGER, default 0: cycles between release of channel i and channel i+1.
REQ-006 Parameter RUN_CYCLES, default 300: run-window length before timeout.
REQ-007 Parameter CNT_W, default 16: width of cycle_count; elaboration SHALL fail if 2**CNT_W <= RUN_CYCLES.
REQ-008 clk  input  1  single clock; all state updates on its rising edge.
REQ-009 reset  input  1  synchronous, active-low reset.
REQ-010 start  input  1  request to begin a sequence; sampled in IDLE and DONE only.
REQ-011 halt  input  CHANNELS  per-channel halt indication from the cores; any bit set ends the run.
REQ-012 core_rst_n  output  CHANNELS  registered active-low reset, one per core.
REQ-013 running  output  1  high while in RUN.
REQ-014 done  output  1  high while in DONE.
REQ-015 timeout  output  1  valid with done; 1 = run ended by window expiry, 0 = ended by halt.
REQ-016 cycle_count  output  CNT_W  number of cycles spent in RUN.

Function
REQ-017 FSM states SHALL be IDLE, PULSE, GAP, RELEASE, RUN, DONE; all outputs SHALL be registered.
REQ-018 IDLE: core_rst_n all 0; start=1 at an edge -> PULSE after that edge; start=0 -> stay.
REQ-019 PULSE: core_rst_n all 0 for exactly PULSE_LEN cycles; the pulse counter increments on exit.
REQ-020 PULSE exit: if fewer than PULSES pulses are complete -> GAP; otherwise -> RELEASE.
REQ-021 GAP: core_rst_n all 1 for exactly GAP_LEN cycles, then -> PULSE; GAP_LEN=0 SHALL merge consecutive pulses into one continuous low.
REQ-022 RELEASE: channel 0 SHALL go high on entry; channel i SHALL go high exactly i*STAGGER cycles after entry; released channels SHALL stay high.
REQ-023 RUN SHALL be entered on the edge that releases channel CHANNELS-1; if STAGGER=0 or CHANNELS=1, PULSE -> RUN directly with all channels high.
REQ-024 RUN: cycle_count SHALL read 0 in the first RUN cycle and increment by 1 every RUN cycle; running=1.
REQ-025 RUN -> DONE with timeout=0 when any halt bit is 1 at an edge; cycle_count in DONE = RUN cycles elapsed including the halt cycle.
REQ-026 RUN -> DONE with timeout=1 after exactly RUN_CYCLES RUN cycles; cycle_count in DONE = RUN_CYCLES.
REQ-027 If halt is asserted on the same edge the window expires, halt SHALL win: timeout=0.
REQ-028 DONE: core_rst_n all 0, done=1, and cycle_count/timeout held until exit.
REQ-029 DONE with start=1 -> PULSE; cycle_count and timeout SHALL clear on that edge; the pulse counter restarts at 0.
REQ-030 start SHALL be ignored in PULSE, GAP, RELEASE and RUN; halt SHALL be ignored outside RUN.
REQ-031 PULSES=0 SHALL behave as PULSES=1.

Reset
REQ-032 reset=0 at an edge SHALL force IDLE, core_rst_n all 0, running=0, done=0, timeout=0, cycle_count=0, pulse counter=0, from any state.
REQ-033 reset=0 concurrent with start=1 SHALL leave the block in IDLE; start is not remembered.
REQ-034 On deassertion of reset, the block SHALL remain in IDLE until start.

Verification
REQ-035 Defaults; start 1 cycle -> core_rst_n pattern 00,11,00, then 11 at RUN entry; running=1; no halt -> after 300 RUN cycles done=1, timeout=1, cycle_count=300, core_rst_n=00.
REQ-036 CHANNELS=4, STAGGER=3, PULSES=1, PULSE_LEN=2 -> core_rst_n low 2 cycles; bits 0,1,2,3 rise at RELEASE+0,3,6,9; running rises with bit 3.
REQ-037 Defaults; halt=2'b10 in RUN cycle 41 (count=41) -> done=1, timeout=0, cycle_count=42; halt=2'b01 on expiry edge -> timeout=0, cycle_count=300.
REQ-038 reset=0 during GAP and again during RUN (count=100) -> next cycle IDLE, core_rst_n=00, cycle_count=0; start then reruns the full sequence from pulse 1.
REQ-039 In DONE, start=1 -> cycle_count=0, timeout=0, new PULSE; start pulsed during RUN -> no effect on state or count.
